scope_frame_packetizer: RTL

SCOPE_FRAME_PACKETIZER -- requirements
Module: scope_frame_packetizer

---
 rtl/scope_frame_packetizer_if.sv | 13 +
 rtl/scope_frame_packetizer.sv | 119 +++++++++++
 2 files changed

// File: rtl/scope_frame_packetizer_if.sv
// Minimal AXI-Stream bundle used for the sample input and the framed scope output.
// The slave view leaves tlast out because the sample side never uses it.
interface axi_stream #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;
    logic                  tlast;

    modport master (output data, output valid, output tlast, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/scope_frame_packetizer.sv
// Buffers scope samples in a FIFO and emits them as fixed-length frames with tlast,
// then waits for the DMA completion pulse before accepting a new frame request.
// Handshake rule for both streams: a beat transfers on a rising edge where valid and
// ready are both 1; once valid is raised, data/tlast/valid hold until that transfer.
module scope_frame_packetizer #(
    parameter int DATA_WIDTH   = 32,
    parameter int FIFO_DEPTH   = 16,
    parameter int LENGTH_WIDTH = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    axi_stream.slave                data_in,
    axi_stream.master               scope_out,
    input  logic                    enable,
    input  logic [LENGTH_WIDTH-1:0] frame_length,
    input  logic                    dma_done,
    output logic                    busy,
    output logic                    overflow,
    output logic [1:0]              state_debug
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, WAIT_DONE = 2'd2} state_t;

    state_t state, state_next;

    logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr, rd_ptr;
    logic [CW-1:0]           count, count_next, readable;
    logic                    in_ready, wr_last, wr_en, rd_en;

    logic [DATA_WIDTH-1:0]   out_data;
    logic                    out_valid, out_last, handshake, load;
    logic [LENGTH_WIDTH-1:0] len_q, beat_cnt, loaded_cnt;

    // A freshly written word becomes readable one cycle later, giving a two-edge
    // path from input acceptance to a valid output beat.
    assign readable   = count - CW'(wr_last);
    assign wr_en      = data_in.valid & in_ready;
    assign load       = (state == STREAM) && (!out_valid || scope_out.ready) &&
                        (readable != '0) && (loaded_cnt < len_q);
    assign rd_en      = load;
    assign count_next = count + CW'(wr_en) - CW'(rd_en);
    assign handshake  = out_valid & scope_out.ready;

    assign data_in.ready   = in_ready;
    assign scope_out.data  = out_data;
    assign scope_out.valid = out_valid;
    assign scope_out.tlast = out_last;
    assign busy            = (state != IDLE);
    assign state_debug     = state;

    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_ptr] <= data_in.data;
    end

    // ready is registered so it stays low throughout reset and rises on the first edge after.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            in_ready <= 1'b0;
            wr_last  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            count    <= count_next;
            in_ready <= (count_next != CW'(FIFO_DEPTH));
            wr_last  <= wr_en;
            if (data_in.valid && !in_ready) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            len_q      <= '0;
            beat_cnt   <= '0;
            loaded_cnt <= '0;
        end else begin
            if (state == IDLE && state_next == STREAM) begin
                len_q      <= frame_length;
                beat_cnt   <= '0;
                loaded_cnt <= '0;
            end else if (handshake) begin
                beat_cnt <= beat_cnt + LENGTH_WIDTH'(1);
            end
            if (load) begin
                out_data   <= mem[rd_ptr];
                out_valid  <= 1'b1;
                out_last   <= (loaded_cnt == len_q - LENGTH_WIDTH'(1));
                loaded_cnt <= loaded_cnt + LENGTH_WIDTH'(1);
            end else if (handshake) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (enable && frame_length != '0) state_next = STREAM;
            STREAM:    if (handshake && beat_cnt == len_q - LENGTH_WIDTH'(1)) state_next = WAIT_DONE;
            WAIT_DONE: if (dma_done) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end
endmodule
